// File: rtl/rsa_seq_pkg.sv
// Shared definitions for the RSA host sequencer: accelerator command codes,
// sequencer states and the job step numbering.
package rsa_seq_pkg;

    localparam int unsigned CMD_W = 32;
    localparam int unsigned STEP_W = 3;

    localparam logic [CMD_W-1:0] CMD_READ    = 32'd0;
    localparam logic [CMD_W-1:0] CMD_COMPUTE = 32'd1;
    localparam logic [CMD_W-1:0] CMD_WRITE   = 32'd2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CMD      = 3'd1,
        S_WDATA    = 3'd2,
        S_WAITDONE = 3'd3,
        S_RDATA    = 3'd4,
        S_FIN      = 3'd5
    } seq_state_e;

    localparam logic [STEP_W-1:0] STEP_MSG     = 3'd0;
    localparam logic [STEP_W-1:0] STEP_EXP     = 3'd1;
    localparam logic [STEP_W-1:0] STEP_N       = 3'd2;
    localparam logic [STEP_W-1:0] STEP_RMODN   = 3'd3;
    localparam logic [STEP_W-1:0] STEP_R2MODN  = 3'd4;
    localparam logic [STEP_W-1:0] STEP_COMPUTE = 3'd5;
    localparam logic [STEP_W-1:0] STEP_WRITE   = 3'd6;

    // Steps 0..4 push operands, then one compute, then one result read-back.
    function automatic logic [CMD_W-1:0] step_cmd(input logic [STEP_W-1:0] step);
        if (step == STEP_COMPUTE) return CMD_COMPUTE;
        if (step == STEP_WRITE)   return CMD_WRITE;
        return CMD_READ;
    endfunction

endpackage

// File: rtl/rsa_host_sequencer.sv
// Host-side job sequencer for an RSA accelerator: pushes five operands, runs a
// compute, reads the result back. Optional watchdog under `SEQ_TIMEOUT_EN`.
module rsa_host_sequencer
    import rsa_seq_pkg::*;
#(
    parameter int unsigned DW      = 1024,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    input  logic [DW-1:0]    msg,
    input  logic [DW-1:0]    exp,
    input  logic [DW-1:0]    n,
    input  logic [DW-1:0]    rmodn,
    input  logic [DW-1:0]    r2modn,
    output logic [DW-1:0]    result,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_valid,
    input  logic             acc_done,
    output logic             acc_done_read,
    output logic [DW-1:0]    wdata,
    output logic             wdata_valid,
    input  logic             wdata_ready,
    input  logic [DW-1:0]    rdata,
    input  logic             rdata_valid,
    output logic             rdata_ready
);

    seq_state_e        state_q;
    logic [STEP_W-1:0] step_q;
    logic [DW-1:0]     op_q [5];
    logic              busy_q;
    logic              done_q;
    logic [DW-1:0]     result_q;
    logic [CMD_W-1:0]  cmd_q;
    logic              cmd_valid_q;
    logic              acc_done_read_q;
    logic [DW-1:0]     wdata_q;
    logic              wdata_valid_q;
    logic              rdata_ready_q;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] timer_q;
    logic          error_q;
    logic          in_wait_c;
    logic          progress_c;

    // Watchdog runs only while parked on the accelerator and resets on any move.
    always_comb begin
        in_wait_c  = 1'b0;
        progress_c = 1'b0;
        case (state_q)
            S_WDATA:    begin in_wait_c = 1'b1; progress_c = wdata_ready; end
            S_RDATA:    begin in_wait_c = 1'b1; progress_c = rdata_valid; end
            S_WAITDONE: begin in_wait_c = 1'b1; progress_c = acc_done;    end
            default:    ;
        endcase
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            step_q          <= STEP_MSG;
            for (int i = 0; i < 5; i++) op_q[i] <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            result_q        <= '0;
            cmd_q           <= '0;
            cmd_valid_q     <= 1'b0;
            acc_done_read_q <= 1'b0;
            wdata_q         <= '0;
            wdata_valid_q   <= 1'b0;
            rdata_ready_q   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            timer_q         <= '0;
            error_q         <= 1'b0;
`endif
        end else begin
            cmd_valid_q     <= 1'b0;
            done_q          <= 1'b0;
            acc_done_read_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            error_q         <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q[0]     <= msg;
                        op_q[1]     <= exp;
                        op_q[2]     <= n;
                        op_q[3]     <= rmodn;
                        op_q[4]     <= r2modn;
                        busy_q      <= 1'b1;
                        step_q      <= STEP_MSG;
                        cmd_q       <= step_cmd(STEP_MSG);
                        cmd_valid_q <= 1'b1;
                        state_q     <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (step_cmd(step_q) == CMD_READ) begin
                        wdata_q       <= op_q[step_q];
                        wdata_valid_q <= 1'b1;
                        state_q       <= S_WDATA;
                    end else if (step_cmd(step_q) == CMD_COMPUTE) begin
                        state_q       <= S_WAITDONE;
                    end else begin
                        rdata_ready_q <= 1'b1;
                        state_q       <= S_RDATA;
                    end
                end
                S_WDATA: begin
                    if (wdata_ready) begin
                        wdata_valid_q <= 1'b0;
                        state_q       <= S_WAITDONE;
                    end
                end
                S_RDATA: begin
                    if (rdata_valid) begin
                        result_q      <= rdata;
                        rdata_ready_q <= 1'b0;
                        state_q       <= S_WAITDONE;
                    end
                end
                S_WAITDONE: begin
                    if (acc_done) begin
                        acc_done_read_q <= 1'b1;
                        if (step_q == STEP_WRITE) begin
                            step_q  <= STEP_MSG;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            step_q      <= STEP_W'(step_q + 3'd1);
                            cmd_q       <= step_cmd(STEP_W'(step_q + 3'd1));
                            cmd_valid_q <= 1'b1;
                            state_q     <= S_CMD;
                        end
                    end
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
`ifdef SEQ_TIMEOUT_EN
            // Later assignments here override the state case on expiry.
            if (!in_wait_c || progress_c) begin
                timer_q <= '0;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
                timer_q       <= '0;
                error_q       <= 1'b1;
                busy_q        <= 1'b0;
                wdata_valid_q <= 1'b0;
                rdata_ready_q <= 1'b0;
                step_q        <= STEP_MSG;
                state_q       <= S_IDLE;
            end else begin
                timer_q <= TW'(timer_q + TW'(1));
            end
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign result        = result_q;
    assign cmd           = cmd_q;
    assign cmd_valid     = cmd_valid_q;
    assign acc_done_read = acc_done_read_q;
    assign wdata         = wdata_q;
    assign wdata_valid   = wdata_valid_q;
    assign rdata_ready   = rdata_ready_q;
`ifdef SEQ_TIMEOUT_EN
    assign error         = error_q;
`else
    assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_host_sequencer.sv
// Directed bench for rsa_host_sequencer with a stub accelerator whose result is
// the XOR of the five operands it received.
module tb_rsa_host_sequencer;

    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst, start;
    logic          busy, done, error;
    logic [DW-1:0] msg, exp, n, rmodn, r2modn, result;
    logic [31:0]   cmd;
    logic          cmd_valid, acc_done, acc_done_read;
    logic [DW-1:0] wdata, rdata;
    logic          wdata_valid, wdata_ready, rdata_valid, rdata_ready;

    rsa_host_sequencer #(.DW(DW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .msg(msg), .exp(exp), .n(n), .rmodn(rmodn), .r2modn(r2modn), .result(result),
        .cmd(cmd), .cmd_valid(cmd_valid), .acc_done(acc_done), .acc_done_read(acc_done_read),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] msg, exp, n, rmodn, r2modn;
        int            wd, dd;
        logic [DW-1:0] res;
        int            lat;
    } vec_t;

    vec_t        vecs[4];
    logic [31:0] exp_cmd[7];
    int          n_tests = 0, n_fail = 0;

    // stub accelerator state
    int            wr_delay, done_delay, wr_cnt, dn_cnt, cyc = 0;
    bit            done_en, dn_pend, wv_prev;
    logic [31:0]   cmd_log[8];
    logic [DW-1:0] wlog[8], last_wdata, acc_xor;
    int            ncmd, nw, n_done, n_err, n_adr, done_at, err_at, hs_cyc, start_cyc;
    int            onehot_viol = 0, stab_viol = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            acc_done = 1'b0; wdata_ready = 1'b0; rdata_valid = 1'b0; rdata = '0;
            wr_cnt = 0; dn_pend = 1'b0; dn_cnt = 0; wv_prev = 1'b0;
        end else begin
            if (done) begin n_done++; done_at = cyc; end
            if (error) begin n_err++; err_at = cyc; end
            if (acc_done_read) n_adr++;
            if (int'(cmd_valid) + int'(wdata_valid) + int'(rdata_ready) > 1) onehot_viol++;
            acc_done = 1'b0;
            if (dn_pend) begin
                dn_cnt++;
                if (done_en && dn_cnt >= done_delay) begin acc_done = 1'b1; dn_pend = 1'b0; end
            end
            if (cmd_valid) begin
                if (ncmd < 8) cmd_log[ncmd] = cmd;
                ncmd++;
                if (cmd == 32'd1) begin dn_pend = 1'b1; dn_cnt = 0; end
            end
            if (wdata_valid) begin
                if (wv_prev && wdata !== last_wdata) stab_viol++;
                wv_prev = 1'b1; last_wdata = wdata;
                if (wr_cnt >= wr_delay) begin
                    wdata_ready = 1'b1;
                    if (nw == 0) hs_cyc = cyc;
                    if (nw < 8) wlog[nw] = wdata;
                    nw++;
                    acc_xor ^= wdata;
                    dn_pend = 1'b1; dn_cnt = 0; wr_cnt = 0;
                end else begin
                    wdata_ready = 1'b0; wr_cnt++;
                end
            end else begin
                wdata_ready = 1'b0; wr_cnt = 0; wv_prev = 1'b0;
            end
            if (rdata_ready) begin
                rdata_valid = 1'b1; rdata = acc_xor; dn_pend = 1'b1; dn_cnt = 0;
            end else begin
                rdata_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        ncmd = 0; nw = 0; acc_xor = '0; n_done = 0; n_err = 0; n_adr = 0;
        done_at = -1; err_at = -1; hs_cyc = -1; dn_pend = 1'b0;
    endtask

    task automatic start_job(input vec_t v);
        wr_delay = v.wd; done_delay = v.dd;
        msg = v.msg; exp = v.exp; n = v.n; rmodn = v.rmodn; r2modn = v.r2modn;
        clear_log();
        start_cyc = cyc + 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        // operands must already be latched
        msg = 16'hdead; exp = 16'hbeef; n = 16'h5555; rmodn = 16'haaaa; r2modn = 16'h7777;
    endtask

    task automatic finish_job(input vec_t v, input string tag);
        int k;
        k = 0;
        while (n_done == 0 && k < 2000) begin tick(); k++; end
        chk({tag, ".done_seen"}, 64'(n_done > 0), 64'd1);
        repeat (3) tick();
        chk({tag, ".done_count"}, 64'(n_done), 64'd1);
        chk({tag, ".latency"}, 64'(done_at - start_cyc), 64'(v.lat));
        chk({tag, ".ncmd"}, 64'(ncmd), 64'd7);
        for (int i = 0; i < 7; i++) chk({tag, ".cmd_seq"}, 64'(cmd_log[i]), 64'(exp_cmd[i]));
        chk({tag, ".nwdata"}, 64'(nw), 64'd5);
        chk({tag, ".wdata_ops"}, {wlog[0], wlog[1], wlog[2], wlog[3]}, {v.msg, v.exp, v.n, v.rmodn});
        chk({tag, ".wdata_r2"}, 64'(wlog[4]), 64'(v.r2modn));
        chk({tag, ".result"}, 64'(result), 64'(v.res));
        chk({tag, ".acc_done_read"}, 64'(n_adr), 64'd7);
        chk({tag, ".busy_after"}, 64'(busy), 64'd0);
        chk({tag, ".no_error"}, 64'(n_err), 64'd0);
    endtask

    task automatic run_job(input vec_t v, input string tag);
        start_job(v);
        chk({tag, ".busy_set"}, 64'(busy), 64'd1);
        finish_job(v, tag);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done_err"}, {62'd0, done, error}, 64'd0);
        chk({tag, ".cmd"}, {31'd0, cmd_valid, cmd}, 64'd0);
        chk({tag, ".wdata"}, {47'd0, wdata_valid, wdata}, 64'd0);
        chk({tag, ".rdy_adr"}, {62'd0, rdata_ready, acc_done_read}, 64'd0);
        chk({tag, ".result"}, 64'(result), 64'd0);
    endtask

    initial begin
        vec_t v;
        int   k;
        rst = 1'b0; start = 1'b0;
        msg = '0; exp = '0; n = '0; rmodn = '0; r2modn = '0;
        done_en = 1'b1; wr_delay = 0; done_delay = 2;
        clear_log();
        exp_cmd = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd2};
        vecs[0] = '{16'h1234, 16'hce7b, 16'hf00d, 16'h0ff2, 16'h0001, 0, 2, 16'h23b1, 28};
        vecs[1] = '{16'h0000, 16'hffff, 16'hffff, 16'h0000, 16'hffff, 1, 1, 16'hffff, 26};
        vecs[2] = '{16'ha5a5, 16'h5a5a, 16'h0f0f, 16'hf0f0, 16'h1111, 3, 3, 16'h1111, 50};
        vecs[3] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 10, 2, 16'h001f, 78};

        #1 rst = 1'b1;
        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run_job(vecs[i], $sformatf("vec%0d", i));

        // start re-pulsed while the compute step is outstanding
        v = vecs[0]; v.dd = 4; v.lat = 42;
        start_job(v);
        k = 0;
        while (ncmd < 6 && k < 500) begin tick(); k++; end
        start = 1'b1; tick(); tick(); start = 1'b0;
        finish_job(v, "ign_start");
        repeat (5) tick();
        chk("ign_start.idle_after", 64'(busy), 64'd0);
        chk("ign_start.no_new_cmd", 64'(ncmd), 64'd7);

        // reset while step 3 operand is being held off
        v = vecs[3];
        start_job(v);
        k = 0;
        while (!(ncmd >= 4 && wdata_valid) && k < 500) begin tick(); k++; end
        chk("midrst.reached_step3", 64'(ncmd), 64'd4);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        tick(); tick();
        chk("midrst.no_done", 64'(n_done), 64'd0);
        rst = 1'b0;
        run_job(vecs[0], "after_rst");

        // accelerator never reports done
        v = vecs[1]; v.wd = 0;
        done_en = 1'b0;
        start_job(v);
`ifdef SEQ_TIMEOUT_EN
        k = 0;
        while (n_err == 0 && k < 200) begin tick(); k++; end
        chk("timeout.error_seen", 64'(n_err > 0), 64'd1);
        chk("timeout.delay", 64'(err_at - hs_cyc), 64'd17);
        chk("timeout.busy", 64'(busy), 64'd0);
        repeat (3) tick();
        chk("timeout.error_pulse", 64'(n_err), 64'd1);
        chk("timeout.hs_low", {61'd0, cmd_valid, wdata_valid, rdata_ready}, 64'd0);
        chk("timeout.no_done", 64'(n_done), 64'd0);
        done_en = 1'b1;
`else
        repeat (40) tick();
        chk("notimeout.busy", 64'(busy), 64'd1);
        chk("notimeout.error", 64'(n_err), 64'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        done_en = 1'b1;
`endif
        run_job(vecs[2], "recover");

        chk("onehot_handshake", 64'(onehot_viol), 64'd0);
        chk("wdata_stable", 64'(stab_viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
